symm_matmul_seq: RTL and testbench
==================================

Name: symm_matmul_seq

Overview:
- Sequencer for the symmetric-matrix multiply datapath (C = A*B, A and B symmetric).
- A and B are each stored only as their upper triangle, row-packed, in two single-port read memories with 1-cycle read latency.
- The block walks i, j, k and folds every (r, c) access with r > c onto (c, r). It drives the external 32-bit MAC with enable and first-term strobes.
- It presents each finished C element on a valid/ready result port. Sits between the host command interface and the MAC/memory datapath.

Parameters:
- N_MAX, 16, largest supported matrix dimension.
- DIM_W, 5, width of dimension and index fields; must satisfy 2**DIM_W > N_MAX.
- TRI_AW, 8, packed-triangle address width; must satisfy 2**TRI_AW >= N_MAX*(N_MAX+1)/2.
- C_AW, 8, C address width; must satisfy 2**C_AW >= N_MAX*N_MAX.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a job; sampled in IDLE only.
- n_cfg  in  DIM_W  matrix dimension, latched on start.
- abort  in  1  synchronous cancel of the current job.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  1-cycle pulse after the last result is accepted.
- cfg_err  out  1  1-cycle pulse when start is rejected.
- rd_en  out  1  read strobe, shared by the A and B memories.
- a_addr  out  TRI_AW  packed address into A.
- b_addr  out  TRI_AW  packed address into B.
- mac_en  out  1  the MAC consumes memory read data this cycle.
- mac_first  out  1  with mac_en: load the product instead of accumulating it.
- res_valid  out  1  a C element is ready on the MAC output.
- res_ready  in  1  the consumer accepts the C element.
- res_row  out  DIM_W  i of the presented element.
- res_col  out  DIM_W  j of the presented element.
- c_addr  out  C_AW  i*N_MAX + j.

Behaviour:
- Reset: FSM goes to IDLE. Every output is 0. Counters i, j, k and the latched n are 0.
- FSM states: IDLE, ISSUE, DRAIN, OUT, DONE.
- IDLE:
  - start with 1 <= n_cfg <= N_MAX: latch n, clear i, j, k, go to ISSUE.
  - start with n_cfg = 0 or n_cfg > N_MAX: cfg_err high for 1 cycle, stay in IDLE.
- ISSUE: one step per cycle, no stalls.
  - rd_en = 1.
  - a_addr = tri(i, k), b_addr = tri(k, j).
  - tri(r, c) = row_base(min) + (max - min), with min/max taken over (r, c).
  - row_base(r) = r*N_MAX - r*(r-1)/2. This is a constant-pitch layout, independent of n.
  - k increments. When k = n-1 is issued, go to DRAIN.
- mac_en is rd_en delayed by 1 cycle. mac_first is (rd_en && k == 0) delayed by 1 cycle.
- DRAIN: 1 cycle. The last mac_en is asserted here. Go to OUT.
- OUT:
  - res_valid = 1. res_row, res_col and c_addr are held stable until res_ready.
  - On res_valid && res_ready:
    - if j < n-1: j increments, k clears, go to ISSUE;
    - else if i < n-1: i increments, j and k clear, go to ISSUE;
    - else go to DONE.
- DONE: done = 1 and busy = 0 for 1 cycle, then IDLE.
- Latency:
  - Start accepted at edge T: first rd_en in cycle T+1.
  - Per element: n issue cycles + 1 drain cycle + at least 1 output cycle.
  - With res_ready held at 1, the job takes n*n*(n+2) + 1 cycles from start to the done pulse.
- abort: honoured in ISSUE, DRAIN and OUT.
  - Next cycle the FSM is in IDLE with all outputs 0.
  - No done pulse; a pending result is dropped.
  - abort in IDLE or DONE has no effect.
- Start while busy is ignored: no cfg_err, and the latched n is unchanged.
- Simultaneous start and abort in IDLE: start wins.
- Asynchronous reset mid-job: immediate return to IDLE. The memory/MAC state is not restored.
- res_ready while res_valid is 0 is ignored.
- The counters never wrap: all index arithmetic stays within DIM_W, because n <= N_MAX < 2**DIM_W.

Decomposition:
- Shared package holds:
  - the state enum;
  - N_MAX, DIM_W, TRI_AW and C_AW constants;
  - function tri_addr(r, c) using row_base.
- One natural sub-module, symm_tri_addr: combinational fold-and-pack. Instantiated twice, once for A and once for B.
- The FSM and counters stay in the top module.

Test Plan:
- n_cfg = 1, res_ready = 1, start at cycle 0:
  - rd_en in cycle 1 with a_addr = 0 and b_addr = 0;
  - mac_en and mac_first in cycle 2;
  - res_valid in cycle 3 with row 0, col 0, c_addr 0;
  - done in cycle 4.
- n_cfg = 3, element (2,0):
  - a_addr sequence 2, 17, 31;
  - b_addr sequence 0, 1, 2;
  - c_addr = 32;
  - 9 results in row-major order; done 46 cycles after start.
- n_cfg = 2, res_ready low for 5 cycles at the first result:
  - res_valid, res_row, res_col and c_addr stay stable;
  - no rd_en until acceptance;
  - the next element's ISSUE starts the cycle after acceptance.
- start with n_cfg = 0, then with n_cfg = 17:
  - cfg_err pulses once for each;
  - busy stays 0; no rd_en.
- n_cfg = 4, abort asserted mid-ISSUE of element (1,2):
  - next cycle all outputs are 0 and the FSM is in IDLE; no done;
  - a following start with n_cfg = 1 completes normally.
- Async reset asserted while in OUT:
  - res_valid and busy drop immediately;
  - after release, IDLE and accepting start.

Source files
------------

// File: rtl/symm_matmul_seq_pkg.sv
// Shared constants, FSM state type and packed upper-triangle address helpers
// for the symmetric-matrix multiply sequencer.
package symm_matmul_seq_pkg;
  localparam int N_MAX  = 16;
  localparam int DIM_W  = 5;
  localparam int TRI_AW = 8;
  localparam int C_AW   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  // Rows are packed at a fixed N_MAX pitch, so a layout never depends on the job's n.
  function automatic logic [15:0] row_base(input logic [DIM_W-1:0] r);
    logic [15:0] r16;
    r16 = 16'(r);
    return r16 * 16'(N_MAX) - ((r16 * (r16 - 16'd1)) >> 1);
  endfunction

  function automatic logic [TRI_AW-1:0] tri_addr(input logic [DIM_W-1:0] r,
                                                 input logic [DIM_W-1:0] c);
    logic [DIM_W-1:0] lo, hi;
    logic [15:0]      t;
    lo = (r < c) ? r : c;
    hi = (r < c) ? c : r;
    t  = row_base(lo) + 16'(hi - lo);
    return t[TRI_AW-1:0];
  endfunction

  function automatic logic [C_AW-1:0] c_index(input logic [DIM_W-1:0] i,
                                              input logic [DIM_W-1:0] j);
    logic [15:0] t;
    t = 16'(i) * 16'(N_MAX) + 16'(j);
    return t[C_AW-1:0];
  endfunction
endpackage

// File: rtl/symm_matmul_seq_tri.sv
// Fold (r, c) onto the stored upper triangle and pack it; zero when idle.
module symm_tri_addr
  import symm_matmul_seq_pkg::*;
(
  input  logic              en,
  input  logic [DIM_W-1:0]  r,
  input  logic [DIM_W-1:0]  c,
  output logic [TRI_AW-1:0] addr
);
  assign addr = en ? tri_addr(r, c) : '0;
endmodule

// File: rtl/symm_matmul_seq.sv
// Walks i, j, k for C = A*B over packed symmetric operands, strobes the MAC
// and hands each finished C element out on a valid/ready port.
module symm_matmul_seq
  import symm_matmul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  n_cfg,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [TRI_AW-1:0] a_addr,
  output logic [TRI_AW-1:0] b_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DIM_W-1:0]  res_row,
  output logic [DIM_W-1:0]  res_col,
  output logic [C_AW-1:0]   c_addr
);
  localparam logic [DIM_W-1:0] N_MAX_D = DIM_W'(N_MAX);
  localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

  state_t           state;
  logic [DIM_W-1:0] n, i, j, k;
  logic [DIM_W-1:0] n_m1;

  assign n_m1 = n - ONE;

  logic [1:0][DIM_W-1:0]  tr, tc;
  logic [1:0][TRI_AW-1:0] taddr;

  // Port 0 reads A(i, k), port 1 reads B(k, j).
  assign tr[0] = i;
  assign tc[0] = k;
  assign tr[1] = k;
  assign tc[1] = j;

  for (genvar g = 0; g < 2; g++) begin : g_tri
    symm_tri_addr u_tri (
      .en  (rd_en),
      .r   (tr[g]),
      .c   (tc[g]),
      .addr(taddr[g])
    );
  end

  assign a_addr  = taddr[0];
  assign b_addr  = taddr[1];
  assign res_row = res_valid ? i : '0;
  assign res_col = res_valid ? j : '0;
  assign c_addr  = res_valid ? c_index(i, j) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n         <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      rd_en     <= 1'b0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      // rd_en is only ever high in ISSUE, so abort here can only mean a live job.
      mac_en    <= rd_en && !abort;
      mac_first <= rd_en && (k == '0) && !abort;
      if (abort && (state == S_ISSUE || state == S_DRAIN || state == S_OUT)) begin
        state     <= S_IDLE;
        i         <= '0;
        j         <= '0;
        k         <= '0;
        busy      <= 1'b0;
        rd_en     <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (n_cfg != '0 && n_cfg <= N_MAX_D) begin
                n     <= n_cfg;
                i     <= '0;
                j     <= '0;
                k     <= '0;
                busy  <= 1'b1;
                rd_en <= 1'b1;
                state <= S_ISSUE;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            if (k == n_m1) begin
              rd_en <= 1'b0;
              state <= S_DRAIN;
            end else begin
              k <= k + ONE;
            end
          end
          S_DRAIN: begin
            res_valid <= 1'b1;
            state     <= S_OUT;
          end
          S_OUT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              k         <= '0;
              if (j < n_m1) begin
                j     <= j + ONE;
                rd_en <= 1'b1;
                state <= S_ISSUE;
              end else if (i < n_m1) begin
                i     <= i + ONE;
                j     <= '0;
                rd_en <= 1'b1;
                state <= S_ISSUE;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_symm_matmul_seq.sv
// Bench for symm_matmul_seq: per-cycle schedule model plus directed scenarios.
module tb_symm_matmul_seq;
  import symm_matmul_seq_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [4:0] n_cfg = '0;
  logic busy, done, cfg_err, rd_en, mac_en, mac_first, res_valid;
  logic [7:0] a_addr, b_addr, c_addr;
  logic [4:0] res_row, res_col;

  symm_matmul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg), .abort(abort),
    .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_first(mac_first),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
    .res_col(res_col), .c_addr(c_addr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tab [16][16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // Schedule model: element e of n*n, phase p (0..n-1 issue, n drain, n+1 output).
  bit m_act, m_done, m_cerr, m_mac, m_macf, m_rd;
  int m_n, m_e, m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_cerr = 0; m_mac = 0; m_macf = 0;
      m_n = 0; m_e = 0; m_p = 0;
    end else begin
      m_rd   = m_act && (m_p < m_n);
      m_mac  = m_rd && !abort;
      m_macf = m_rd && (m_p == 0) && !abort;
      m_cerr = 0;
      if (m_done) m_done = 0;
      else if (!m_act) begin
        if (start) begin
          if (int'(n_cfg) >= 1 && int'(n_cfg) <= 16) begin
            m_act = 1; m_n = int'(n_cfg); m_e = 0; m_p = 0;
          end else m_cerr = 1;
        end
      end else if (abort) m_act = 0;
      else if (m_p < m_n + 1) m_p++;
      else if (res_ready) begin
        if (m_e == m_n * m_n - 1) begin m_act = 0; m_done = 1; end
        else begin m_e++; m_p = 0; end
      end
    end
  end

  logic [40:0] exp_v, got_v;
  logic [7:0]  ea, eb, ec;
  logic [4:0]  er, ecl;
  bit          erd, ev;
  int          mi, mj;

  always @(negedge clk) begin
    erd = m_act && (m_p < m_n);
    ev  = m_act && (m_p == m_n + 1);
    mi  = (m_n > 0) ? m_e / m_n : 0;
    mj  = (m_n > 0) ? m_e % m_n : 0;
    ea  = erd ? 8'(tab[mi][m_p]) : 8'd0;
    eb  = erd ? 8'(tab[m_p][mj]) : 8'd0;
    er  = ev ? 5'(mi) : 5'd0;
    ecl = ev ? 5'(mj) : 5'd0;
    ec  = ev ? 8'(mi * 16 + mj) : 8'd0;
    exp_v = {m_act, m_done, m_cerr, erd, ea, eb, m_mac, m_macf, ev, er, ecl, ec};
    got_v = {busy, done, cfg_err, rd_en, a_addr, b_addr, mac_en, mac_first,
             res_valid, res_row, res_col, c_addr};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t actual %h expected %h", $time, got_v, exp_v);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int rc, na, nk, cnt, ga[8], gb[8];
  bit seen;

  task automatic wait_done(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ok = 1;
    end
    chk({nm, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (res_valid) ok = 1;
    end
    chk({nm, "_valid_seen"}, int'(ok), 1);
  endtask

  initial begin
    cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = r; c < 16; c++) begin
        tab[r][c] = cnt; tab[c][r] = cnt; cnt++;
      end
    chk("tab_2_0", tab[2][0], 2);
    chk("tab_2_1", tab[2][1], 17);
    chk("tab_2_2", tab[2][2], 31);
    chk("tab_15_15", tab[15][15], 135);

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // n = 1 timing
    start = 1'b1; n_cfg = 5'd1;
    @(negedge clk); start = 1'b0;
    chk("n1_rd_en", int'(rd_en), 1);
    chk("n1_a_addr", int'(a_addr), 0);
    chk("n1_b_addr", int'(b_addr), 0);
    @(negedge clk);
    chk("n1_mac_en", int'(mac_en), 1);
    chk("n1_mac_first", int'(mac_first), 1);
    @(negedge clk);
    chk("n1_res_valid", int'(res_valid), 1);
    chk("n1_c_addr", int'(c_addr), 0);
    @(negedge clk);
    chk("n1_done", int'(done), 1);
    chk("n1_busy_at_done", int'(busy), 0);
    @(negedge clk);

    // n = 3 full job
    start = 1'b1; n_cfg = 5'd3;
    rc = 0; na = 0; seen = 0;
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (rd_en && rc == 6 && na < 8) begin ga[na] = a_addr; gb[na] = b_addr; na++; end
      if (res_valid) begin
        chk("n3_row", int'(res_row), rc / 3);
        chk("n3_col", int'(res_col), rc % 3);
        if (rc == 6) chk("n3_c_addr_2_0", int'(c_addr), 32);
        rc++;
      end
      if (done) begin chk("n3_done_cycle", cyc, 46); seen = 1; end
    end
    chk("n3_done_seen", int'(seen), 1);
    chk("n3_results", rc, 9);
    chk("n3_issues_2_0", na, 3);
    chk("n3_a0", ga[0], 2);  chk("n3_a1", ga[1], 17); chk("n3_a2", ga[2], 31);
    chk("n3_b0", gb[0], 0);  chk("n3_b1", gb[1], 1);  chk("n3_b2", gb[2], 2);
    @(negedge clk);

    // n = 2 with back-pressure on the first result
    res_ready = 1'b0;
    start = 1'b1; n_cfg = 5'd2;
    wait_valid("n2", 20);
    for (int q = 0; q < 5; q++) begin
      chk("n2_hold_valid", int'(res_valid), 1);
      chk("n2_hold_row", int'(res_row), 0);
      chk("n2_hold_col", int'(res_col), 0);
      chk("n2_hold_c_addr", int'(c_addr), 0);
      chk("n2_hold_no_rd", int'(rd_en), 0);
      if (q == 4) res_ready = 1'b1;
      @(negedge clk);
    end
    chk("n2_next_issue", int'(rd_en), 1);
    chk("n2_next_valid_low", int'(res_valid), 0);
    chk("n2_next_b_addr", int'(b_addr), 1);
    wait_done("n2", 40);
    @(negedge clk);

    // rejected configurations
    start = 1'b1; n_cfg = 5'd0;
    @(negedge clk); start = 1'b0;
    chk("n0_cfg_err", int'(cfg_err), 1);
    chk("n0_busy", int'(busy), 0);
    @(negedge clk);
    chk("n0_cfg_err_pulse", int'(cfg_err), 0);
    chk("n0_rd_en", int'(rd_en), 0);
    start = 1'b1; n_cfg = 5'd17;
    @(negedge clk); start = 1'b0;
    chk("n17_cfg_err", int'(cfg_err), 1);
    chk("n17_busy", int'(busy), 0);
    @(negedge clk);
    chk("n17_cfg_err_pulse", int'(cfg_err), 0);
    chk("n17_rd_en", int'(rd_en), 0);

    // n = 4, abort on the second issue cycle of element (1,2)
    start = 1'b1; n_cfg = 5'd4;
    rc = 0; nk = 0; seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (res_valid) rc++;
      if (rd_en && rc == 6) begin
        nk++;
        if (nk == 2) begin
          chk("ab_a_addr_1_1", int'(a_addr), 16);
          chk("ab_b_addr_1_2", int'(b_addr), 17);
          abort = 1'b1; seen = 1;
        end
      end
    end
    chk("ab_reached", int'(seen), 1);
    @(negedge clk); abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_rd_en", int'(rd_en), 0);
    chk("ab_mac_en", int'(mac_en), 0);
    chk("ab_done", int'(done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_no_done", int'(done), 0);
    end
    start = 1'b1; n_cfg = 5'd1;
    wait_done("ab_restart", 10);
    @(negedge clk);

    // asynchronous reset while a result is pending
    res_ready = 1'b0;
    start = 1'b1; n_cfg = 5'd2;
    wait_valid("rst", 20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; n_cfg = 5'd1;
    @(negedge clk); start = 1'b0;
    chk("arst_restart_rd", int'(rd_en), 1);
    chk("arst_restart_busy", int'(busy), 1);
    wait_done("arst_restart", 10);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
